// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART command controller: opcodes, FSM state
// encoding and the register-file addresses that hold the ALU operands.
package uart_cmd_ctrl_pkg;

  localparam logic [7:0] CMD_REG_WR  = 8'hAA;
  localparam logic [7:0] CMD_REG_RD  = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_OP_A,
    ST_OP_B,
    ST_ALU_FN,
    ST_ALU_WAIT,
    ST_TX_BYTE0,
    ST_TX_BYTE1
  } state_e;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Bundle of the controller's UART RX, register-file, ALU and TX FIFO signals.
// master = command controller, slave = surrounding system.
interface uart_cmd_ctrl_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_FUN_WIDTH = 4
) ();

  logic [DATA_WIDTH-1:0]    RX_P_DATA;
  logic                     RX_data_valid;
  logic                     parity_error;
  logic                     framing_error;

  logic [ADDR_WIDTH-1:0]    RF_Address;
  logic                     RF_WrEn;
  logic                     RF_RdEn;
  logic [DATA_WIDTH-1:0]    RF_WrData;
  logic [DATA_WIDTH-1:0]    RF_RdData;
  logic                     RF_RdData_valid;

  logic [ALU_FUN_WIDTH-1:0] ALU_FUN;
  logic                     ALU_EN;
  logic                     CLKG_EN;
  logic [2*DATA_WIDTH-1:0]  ALU_OUT;
  logic                     ALU_OUT_valid;

  logic [DATA_WIDTH-1:0]    TX_P_DATA;
  logic                     TX_D_VLD;
  logic                     FIFO_full;

  modport master (
    input  RX_P_DATA, RX_data_valid, parity_error, framing_error,
    output RF_Address, RF_WrEn, RF_RdEn, RF_WrData,
    input  RF_RdData, RF_RdData_valid,
    output ALU_FUN, ALU_EN, CLKG_EN,
    input  ALU_OUT, ALU_OUT_valid,
    output TX_P_DATA, TX_D_VLD,
    input  FIFO_full
  );

  modport slave (
    output RX_P_DATA, RX_data_valid, parity_error, framing_error,
    input  RF_Address, RF_WrEn, RF_RdEn, RF_WrData,
    output RF_RdData, RF_RdData_valid,
    input  ALU_FUN, ALU_EN, CLKG_EN,
    output ALU_OUT, ALU_OUT_valid,
    input  TX_P_DATA, TX_D_VLD,
    output FIFO_full
  );

endinterface

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: decodes RX command frames into register-file and
// ALU operations and returns read/ALU results over the TX FIFO path.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_FUN_WIDTH = 4
) (
  input  logic            CLK,
  input  logic            RST,
  uart_cmd_ctrl_if.master bus
);

  state_e                   state_q,     state_d;
  logic [ADDR_WIDTH-1:0]    rf_addr_q,   rf_addr_d;
  logic [DATA_WIDTH-1:0]    rf_wrdata_q, rf_wrdata_d;
  logic                     rf_wren_q,   rf_wren_d;
  logic                     rf_rden_q,   rf_rden_d;
  logic [ALU_FUN_WIDTH-1:0] alu_fun_q,   alu_fun_d;
  logic                     alu_en_q,    alu_en_d;
  logic                     clkg_en_q,   clkg_en_d;
  logic [DATA_WIDTH-1:0]    tx_data_q,   tx_data_d;
  logic                     tx_vld_q,    tx_vld_d;
  logic [2*DATA_WIDTH-1:0]  res_q,       res_d;
  logic                     two_byte_q,  two_byte_d;

  logic                     rx_ok;
  logic                     rx_err;
  logic [DATA_WIDTH-1:0]    rx_byte;

  assign rx_byte = bus.RX_P_DATA;
  assign rx_ok   = bus.RX_data_valid & ~bus.parity_error & ~bus.framing_error;
  assign rx_err  = bus.RX_data_valid & (bus.parity_error | bus.framing_error);

  always_comb begin
    state_d     = state_q;
    rf_addr_d   = rf_addr_q;
    rf_wrdata_d = rf_wrdata_q;
    alu_fun_d   = alu_fun_q;
    clkg_en_d   = clkg_en_q;
    tx_data_d   = tx_data_q;
    res_d       = res_q;
    two_byte_d  = two_byte_q;
    rf_wren_d   = 1'b0;
    rf_rden_d   = 1'b0;
    alu_en_d    = 1'b0;
    tx_vld_d    = 1'b0;

    // A corrupted byte aborts whatever frame is in progress, from any state.
    if (rx_err) begin
      state_d   = ST_IDLE;
      clkg_en_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          clkg_en_d = 1'b0;
          if (rx_ok) begin
            case (rx_byte)
              DATA_WIDTH'(CMD_REG_WR):  state_d = ST_WR_ADDR;
              DATA_WIDTH'(CMD_REG_RD):  state_d = ST_RD_ADDR;
              DATA_WIDTH'(CMD_ALU_OP):  state_d = ST_OP_A;
              DATA_WIDTH'(CMD_ALU_NOP): state_d = ST_ALU_FN;
              default:                  state_d = ST_IDLE;
            endcase
          end
        end
        ST_WR_ADDR: begin
          if (rx_ok) begin
            rf_addr_d = rx_byte[ADDR_WIDTH-1:0];
            state_d   = ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (rx_ok) begin
            rf_wrdata_d = rx_byte;
            rf_wren_d   = 1'b1;
            state_d     = ST_IDLE;
          end
        end
        ST_RD_ADDR: begin
          if (rx_ok) begin
            rf_addr_d = rx_byte[ADDR_WIDTH-1:0];
            rf_rden_d = 1'b1;
            state_d   = ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (bus.RF_RdData_valid) begin
            res_d      = {{DATA_WIDTH{1'b0}}, bus.RF_RdData};
            two_byte_d = 1'b0;
            state_d    = ST_TX_BYTE0;
          end
        end
        ST_OP_A: begin
          if (rx_ok) begin
            rf_addr_d   = ADDR_WIDTH'(OPA_ADDR);
            rf_wrdata_d = rx_byte;
            rf_wren_d   = 1'b1;
            state_d     = ST_OP_B;
          end
        end
        ST_OP_B: begin
          if (rx_ok) begin
            rf_addr_d   = ADDR_WIDTH'(OPB_ADDR);
            rf_wrdata_d = rx_byte;
            rf_wren_d   = 1'b1;
            state_d     = ST_ALU_FN;
          end
        end
        ST_ALU_FN: begin
          // Gate enable and ALU enable rise together so ALU_EN never sees a stopped clock.
          if (rx_ok) begin
            alu_fun_d = rx_byte[ALU_FUN_WIDTH-1:0];
            clkg_en_d = 1'b1;
            alu_en_d  = 1'b1;
            state_d   = ST_ALU_WAIT;
          end
        end
        ST_ALU_WAIT: begin
          if (bus.ALU_OUT_valid) begin
            res_d      = bus.ALU_OUT;
            two_byte_d = 1'b1;
            clkg_en_d  = 1'b0;
            state_d    = ST_TX_BYTE0;
          end
        end
        ST_TX_BYTE0: begin
          if (!bus.FIFO_full) begin
            tx_data_d = res_q[DATA_WIDTH-1:0];
            tx_vld_d  = 1'b1;
            state_d   = two_byte_q ? ST_TX_BYTE1 : ST_IDLE;
          end
        end
        ST_TX_BYTE1: begin
          if (!bus.FIFO_full) begin
            tx_data_d = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
            tx_vld_d  = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      rf_addr_q   <= '0;
      rf_wrdata_q <= '0;
      rf_wren_q   <= 1'b0;
      rf_rden_q   <= 1'b0;
      alu_fun_q   <= '0;
      alu_en_q    <= 1'b0;
      clkg_en_q   <= 1'b0;
      tx_data_q   <= '0;
      tx_vld_q    <= 1'b0;
      res_q       <= '0;
      two_byte_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rf_addr_q   <= rf_addr_d;
      rf_wrdata_q <= rf_wrdata_d;
      rf_wren_q   <= rf_wren_d;
      rf_rden_q   <= rf_rden_d;
      alu_fun_q   <= alu_fun_d;
      alu_en_q    <= alu_en_d;
      clkg_en_q   <= clkg_en_d;
      tx_data_q   <= tx_data_d;
      tx_vld_q    <= tx_vld_d;
      res_q       <= res_d;
      two_byte_q  <= two_byte_d;
    end
  end

  assign bus.RF_Address = rf_addr_q;
  assign bus.RF_WrData  = rf_wrdata_q;
  assign bus.RF_WrEn    = rf_wren_q;
  assign bus.RF_RdEn    = rf_rden_q;
  assign bus.ALU_FUN    = alu_fun_q;
  assign bus.ALU_EN     = alu_en_q;
  assign bus.CLKG_EN    = clkg_en_q;
  assign bus.TX_P_DATA  = tx_data_q;
  assign bus.TX_D_VLD   = tx_vld_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed frames then random command traffic,
// checked against a transaction-level model of expected RF/ALU/TX events.
module tb_uart_cmd_ctrl;
  import uart_cmd_ctrl_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int FW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_cmd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALU_FUN_WIDTH(FW)) bus ();

  uart_cmd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALU_FUN_WIDTH(FW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] wr_q[$],  exp_wr[$];
  logic [3:0]  rd_q[$],  exp_rd[$];
  logic [3:0]  alu_q[$], exp_alu[$];
  logic [7:0]  tx_q[$],  exp_tx[$];
  logic [7:0]  env_rf[16] = '{default: 8'h00};
  logic [7:0]  mdl_rf[16] = '{default: 8'h00};
  logic        prev_full = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] alu_f(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return {8'h00, a & b};
      4'd4:    return {a, b};
      default: return {8'h00, a ^ b};
    endcase
  endfunction

  // Environment side: record every strobe, act as the register file, watch invariants.
  always @(negedge clk) begin
    if (!rst) begin
      chk("wr_rd_excl", 32'(bus.RF_WrEn & bus.RF_RdEn), 32'd0);
      chk("alu_en_gated", 32'(bus.ALU_EN & ~bus.CLKG_EN), 32'd0);
      chk("tx_while_full", 32'(bus.TX_D_VLD & prev_full), 32'd0);
      if (bus.RF_WrEn) begin
        wr_q.push_back({bus.RF_Address, bus.RF_WrData});
        env_rf[bus.RF_Address] <= bus.RF_WrData;
      end
      if (bus.RF_RdEn)  rd_q.push_back(bus.RF_Address);
      if (bus.ALU_EN)   alu_q.push_back(bus.ALU_FUN);
      if (bus.TX_D_VLD) tx_q.push_back(bus.TX_P_DATA);
    end
    prev_full <= rst ? 1'b0 : bus.FIFO_full;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic gap();
    idle($urandom_range(0, 2));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic perr, input logic ferr);
    @(posedge clk); #1;
    bus.RX_P_DATA     = b;
    bus.RX_data_valid = 1'b1;
    bus.parity_error  = perr;
    bus.framing_error = ferr;
    @(posedge clk); #1;
    bus.RX_data_valid = 1'b0;
    bus.parity_error  = 1'b0;
    bus.framing_error = 1'b0;
    bus.RX_P_DATA     = 8'($urandom);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"},  32'(bus.RF_Address), 32'd0);
    chk({tag, "_wren"},  32'(bus.RF_WrEn),    32'd0);
    chk({tag, "_rden"},  32'(bus.RF_RdEn),    32'd0);
    chk({tag, "_wdata"}, 32'(bus.RF_WrData),  32'd0);
    chk({tag, "_fun"},   32'(bus.ALU_FUN),    32'd0);
    chk({tag, "_aluen"}, 32'(bus.ALU_EN),     32'd0);
    chk({tag, "_clkg"},  32'(bus.CLKG_EN),    32'd0);
    chk({tag, "_txd"},   32'(bus.TX_P_DATA),  32'd0);
    chk({tag, "_txv"},   32'(bus.TX_D_VLD),   32'd0);
  endtask

  task automatic compare_all(input string tag);
    idle(3);
    chk({tag, "_wr_n"}, 32'(wr_q.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) chk({tag, "_wr"}, 32'(wr_q[i]), 32'(exp_wr[i]));
    chk({tag, "_rd_n"}, 32'(rd_q.size()), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++) chk({tag, "_rd"}, 32'(rd_q[i]), 32'(exp_rd[i]));
    chk({tag, "_alu_n"}, 32'(alu_q.size()), 32'(exp_alu.size()));
    for (int i = 0; i < exp_alu.size() && i < alu_q.size(); i++) chk({tag, "_alu"}, 32'(alu_q[i]), 32'(exp_alu[i]));
    chk({tag, "_tx_n"}, 32'(tx_q.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++) chk({tag, "_tx"}, 32'(tx_q[i]), 32'(exp_tx[i]));
    wr_q.delete();  exp_wr.delete();
    rd_q.delete();  exp_rd.delete();
    alu_q.delete(); exp_alu.delete();
    tx_q.delete();  exp_tx.delete();
  endtask

  task automatic wait_tx(input string tag);
    for (int i = 0; i < 200 && tx_q.size() < exp_tx.size(); i++) @(negedge clk);
    chk({tag, "_tx_done"}, 32'(tx_q.size() >= exp_tx.size()), 32'd1);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    send_byte(CMD_REG_WR, 1'b0, 1'b0); gap();
    send_byte({4'($urandom), a}, 1'b0, 1'b0); gap();
    send_byte(d, 1'b0, 1'b0);
    exp_wr.push_back({a, d});
    mdl_rf[a] = d;
  endtask

  task automatic do_read(input logic [3:0] a, input bit junk, input int stall);
    logic [3:0] ra;
    send_byte(CMD_REG_RD, 1'b0, 1'b0); gap();
    send_byte({4'($urandom), a}, 1'b0, 1'b0);
    exp_rd.push_back(a);
    exp_tx.push_back(mdl_rf[a]);
    for (int i = 0; i < 40 && rd_q.size() == 0; i++) @(negedge clk);
    chk("rd_req_seen", 32'(rd_q.size() != 0), 32'd1);
    ra = (rd_q.size() != 0) ? rd_q[0] : 4'h0;
    if (junk) send_byte(8'($urandom), 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.RF_RdData       = env_rf[ra];
    bus.RF_RdData_valid = 1'b1;
    bus.FIFO_full       = (stall > 0);
    @(posedge clk); #1;
    bus.RF_RdData_valid = 1'b0;
    if (stall > 0) begin
      idle(stall);
      chk("rd_stall_hold", 32'(tx_q.size()), 32'd0);
      bus.FIFO_full = 1'b0;
    end
    wait_tx("rd");
  endtask

  task automatic do_alu(input bit with_ops, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] f, input int stall, input bit junk);
    logic [15:0] r;
    if (with_ops) begin
      send_byte(CMD_ALU_OP, 1'b0, 1'b0); gap();
      send_byte(a, 1'b0, 1'b0); gap();
      send_byte(b, 1'b0, 1'b0); gap();
      exp_wr.push_back({4'd0, a});
      exp_wr.push_back({4'd1, b});
      mdl_rf[0] = a;
      mdl_rf[1] = b;
    end else begin
      send_byte(CMD_ALU_NOP, 1'b0, 1'b0); gap();
    end
    send_byte(f, 1'b0, 1'b0);
    exp_alu.push_back(f[3:0]);
    r = alu_f(f[3:0], mdl_rf[0], mdl_rf[1]);
    exp_tx.push_back(r[7:0]);
    exp_tx.push_back(r[15:8]);
    for (int i = 0; i < 40 && alu_q.size() == 0; i++) @(negedge clk);
    chk("alu_en_seen", 32'(alu_q.size() != 0), 32'd1);
    if (junk) send_byte(8'($urandom), 1'b0, 1'b0);
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      chk("clkg_wait", 32'(bus.CLKG_EN), 32'd1);
    end
    @(posedge clk); #1;
    bus.ALU_OUT       = alu_f(bus.ALU_FUN, env_rf[0], env_rf[1]);
    bus.ALU_OUT_valid = 1'b1;
    bus.FIFO_full     = (stall > 0);
    @(posedge clk); #1;
    bus.ALU_OUT_valid = 1'b0;
    if (stall > 0) begin
      idle(stall);
      chk("alu_stall_hold", 32'(tx_q.size()), 32'd0);
      bus.FIFO_full = 1'b0;
    end
    wait_tx("alu");
    idle(1);
    chk("clkg_off", 32'(bus.CLKG_EN), 32'd0);
  endtask

  task automatic do_err(input int kind);
    logic [7:0] a;
    logic       pe;
    a  = 8'($urandom);
    pe = 1'($urandom);
    case (kind)
      0: begin send_byte(CMD_REG_WR, 1'b0, 1'b0); send_byte(a, 1'b0, 1'b0); end
      1: send_byte(CMD_REG_RD, 1'b0, 1'b0);
      2: begin
           send_byte(CMD_ALU_OP, 1'b0, 1'b0);
           send_byte(a, 1'b0, 1'b0);
           exp_wr.push_back({4'd0, a});
           mdl_rf[0] = a;
         end
      default: send_byte(CMD_ALU_NOP, 1'b0, 1'b0);
    endcase
    send_byte(8'($urandom), pe, ~pe);
  endtask

  initial begin
    logic [7:0] junk_b;
    int         kind;
    rst                 = 1'b1;
    bus.RX_P_DATA       = '0;
    bus.RX_data_valid   = 1'b0;
    bus.parity_error    = 1'b0;
    bus.framing_error   = 1'b0;
    bus.RF_RdData       = '0;
    bus.RF_RdData_valid = 1'b0;
    bus.ALU_OUT         = '0;
    bus.ALU_OUT_valid   = 1'b0;
    bus.FIFO_full       = 1'b0;
    idle(2);
    check_zero("reset");
    rst = 1'b0;

    do_write(4'h5, 8'h3C);
    compare_all("wr_5_3c");

    do_read(4'h5, 1'b0, 0);
    compare_all("rd_5");

    do_alu(1'b1, 8'h0A, 8'h03, 8'h00, 0, 1'b0);
    compare_all("alu_add");

    do_alu(1'b0, 8'h00, 8'h00, 8'h02, 20, 1'b0);
    compare_all("alu_stall");

    send_byte(CMD_REG_WR, 1'b0, 1'b0);
    send_byte(8'h05, 1'b0, 1'b0);
    send_byte(8'h99, 1'b1, 1'b0);
    compare_all("parity_abort");
    do_write(4'h6, 8'h11);
    compare_all("wr_after_err");

    // Reset while waiting for the second operand.
    send_byte(CMD_ALU_OP, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b0);
    exp_wr.push_back({4'd0, 8'h5A});
    mdl_rf[0] = 8'h5A;
    idle(1);
    rst = 1'b1;
    #1;
    check_zero("rst_opb");
    idle(3);
    check_zero("rst_hold");
    rst = 1'b0;
    send_byte(8'h77, 1'b0, 1'b0);
    compare_all("after_rst");
    do_read(4'h0, 1'b0, 0);
    compare_all("rd_after_rst");

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 5))
        0: do_write(4'($urandom), 8'($urandom));
        1: do_read(4'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0);
        2: do_alu(1'b1, 8'($urandom), 8'($urandom), 8'($urandom_range(0, 6)),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0, 1'($urandom));
        3: do_alu(1'b0, 8'h00, 8'h00, 8'($urandom), 0, 1'($urandom));
        4: begin
             do
               junk_b = 8'($urandom);
             while (junk_b == CMD_REG_WR || junk_b == CMD_REG_RD ||
                    junk_b == CMD_ALU_OP || junk_b == CMD_ALU_NOP);
             send_byte(junk_b, 1'b0, 1'b0);
           end
        default: begin
             kind = $urandom_range(0, 3);
             do_err(kind);
           end
      endcase
      compare_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of every UART byte, register word and ALU operand.
REQ-002 Parameter ADDR_WIDTH, default 4: register-file address width.
REQ-003 Parameter ALU_FUN_WIDTH, default 4: ALU function-code width.
REQ-004 Port CLK  in  1: single system clock; all logic rising-edge.
REQ-005 Port RST  in  1: reset, asynchronous, active-high.
REQ-006 Port RX_P_DATA  in  DATA_WIDTH: received byte from UART receiver.
REQ-007 Port RX_data_valid  in  1: one-cycle pulse per received byte.
REQ-008 Port parity_error / framing_error  in  1 each: error flags for the byte qualified by RX_data_valid.
REQ-009 Port RF_Address  out  ADDR_WIDTH; RF_WrEn, RF_RdEn  out  1; RF_WrData  out  DATA_WIDTH: register-file control.
REQ-010 Port RF_RdData  in  DATA_WIDTH; RF_RdData_valid  in  1: register-file read return.
REQ-011 Port ALU_FUN  out  ALU_FUN_WIDTH; ALU_EN  out  1; CLKG_EN  out  1: ALU control and ALU clock-gate enable.
REQ-012 Port ALU_OUT  in  2*DATA_WIDTH; ALU_OUT_valid  in  1: ALU result return.
REQ-013 Port TX_P_DATA  out  DATA_WIDTH; TX_D_VLD  out  1; FIFO_full  in  1: response path to TX FIFO.

Function
REQ-014 Command bytes decoded in IDLE: 0xAA reg write, 0xBB reg read, 0xCC ALU with operands, 0xDD ALU without operands; any other byte ignored, state stays IDLE.
REQ-015 FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FN, ALU_WAIT, TX_BYTE0, TX_BYTE1.
REQ-016 Byte consumed only on cycle with RX_data_valid=1 and both error flags 0.
REQ-017 Byte with parity_error or framing_error in any state: byte discarded, FSM returns to IDLE next cycle, no RF/ALU/TX strobe issued.
REQ-018 0xAA: IDLE->WR_ADDR; address byte latched (low ADDR_WIDTH bits) ->WR_DATA; data byte -> RF_WrEn=1 for exactly one cycle, following the data byte's valid cycle, with RF_Address/RF_WrData stable that cycle; ->IDLE.
REQ-019 0xBB: IDLE->RD_ADDR; address byte -> RF_RdEn one-cycle pulse, ->RD_WAIT; on RF_RdData_valid capture RF_RdData ->TX_BYTE0 (single-byte response); ->IDLE after send.
REQ-020 0xCC: OP_A byte written to RF address 0, OP_B byte written to RF address 1 (one-cycle RF_WrEn each, as REQ-018), then ->ALU_FN.
REQ-021 0xDD: IDLE->ALU_FN directly, operands reuse current RF addresses 0/1.
REQ-022 ALU_FN: function byte latched into ALU_FUN (low ALU_FUN_WIDTH bits), CLKG_EN=1 and ALU_EN one-cycle pulse next cycle, ->ALU_WAIT.
REQ-023 ALU_WAIT: CLKG_EN held 1; on ALU_OUT_valid capture ALU_OUT, CLKG_EN=0 next cycle, ->TX_BYTE0; response = low byte then high byte.
REQ-024 TX_BYTE0/TX_BYTE1: TX_D_VLD one-cycle pulse with TX_P_DATA when FIFO_full=0; while FIFO_full=1 hold state, TX_D_VLD=0, data held.
REQ-025 RX bytes arriving during RD_WAIT, ALU_WAIT or TX states are dropped; no queuing.
REQ-026 RF_WrEn and RF_RdEn never asserted in the same cycle; ALU_EN never asserted with CLKG_EN=0.
REQ-027 At most one TX_D_VLD pulse per byte; read response 1 byte, ALU response exactly 2 bytes.

Reset
REQ-028 RST=1 forces state IDLE and all outputs 0 (RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_FUN, ALU_EN, CLKG_EN, TX_P_DATA, TX_D_VLD) asynchronously.
REQ-029 Reset mid-frame discards partial command and captured results; first valid byte after release is decoded as a command.

Structure
REQ-030 Shared package holds command opcodes (0xAA/0xBB/0xCC/0xDD), FSM state encoding and operand RF addresses 0/1.
REQ-031 Single module, no sub-modules; FSM next-state and output registers in one file.

Verification
REQ-032 Bytes AA,05,3C -> one-cycle RF_WrEn, RF_Address=5, RF_WrData=3C; no TX_D_VLD.
REQ-033 Bytes BB,05; RF_RdData=3C with valid -> single TX_D_VLD, TX_P_DATA=3C.
REQ-034 Bytes CC,0A,03,00 (add), ALU_OUT=000D -> writes addr0=0A, addr1=03; TX bytes 0D then 00; CLKG_EN low after.
REQ-035 Bytes DD,02 with FIFO_full=1 for 20 cycles at result -> TX_D_VLD held low, then bytes sent in order after FIFO_full=0.
REQ-036 Bytes AA,05 then data byte with parity_error=1 -> no RF_WrEn, FSM IDLE; following AA,06,11 writes normally.
REQ-037 RST=1 asserted in OP_B state -> outputs 0 immediately; unknown byte 77 after release ignored.
